dmem_stream_port: RTL and testbench
===================================

Name: dmem_stream_port

Overview:
- Memory-mapped responder on the CPU core's data-memory bus: daddr/ddata_w/d_w/d_r in, ddata_r out.
- Gives software a TX FIFO, which the CPU writes and an external stream consumer drains, and an RX FIFO, which an external producer fills and the CPU reads.
- Sits beside the data RAM. Its ddata_r is ORed into the core's read-data path and is zero when not selected.

Parameters:
- BASE_ADDR, 10'h3F0, byte base address of the 16-byte register window; bits [3:0] must be 0.
- DEPTH, 8, entries per FIFO; power of two, 2..128.

Ports:
- CLK  input  1  clock, all state updates on rising edge
- RST  input  1  synchronous, active-high reset
- daddr  input  10  byte address from core
- ddata_w  input  32  write data from core
- d_w  input  1  store strobe
- d_r  input  1  load strobe
- ddata_r  output  32  load data; 0 when not (sel && d_r)
- sel  output  1  combinational, daddr[9:4]==BASE_ADDR[9:4]
- tx_data  output  32  TX FIFO head
- tx_valid  output  1  TX FIFO not empty
- tx_ready  input  1  consumer accepts head
- rx_data  input  32  producer word
- rx_valid  input  1  producer word valid
- rx_ready  output  1  RX FIFO not full
- irq  output  1  interrupt (see Optional Feature)

Behaviour:
- Register map, word offset daddr[3:2]; daddr[1:0] ignored, no byte enables:
  - 0 TXDATA: write pushes ddata_w; read returns 0.
  - 1 RXDATA: read returns the RX head and pops it at the clock edge; write ignored.
  - 2 STATUS, read-only: [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] tx_ovf, [5] rx_unf, [15:8] tx_count, [23:16] rx_count, other bits 0.
  - 3 CTRL: write bit0=flush (self-clearing, not stored), bit1=ie (stored), bit2=clear sticky flags (self-clearing). Read returns {30'b0, ie, 1'b0}.
- Read timing: ddata_r is combinational from daddr and FIFO state in the same cycle, as needed by the single-cycle core. All side effects (push, pop, flag set/clear) occur on the rising edge where d_w or d_r is sampled high with sel=1.
- d_w and d_r both high at the same address: write action and read action both take effect.
- TX FIFO: circular buffer, wrap-around pointers, count 0..DEPTH.
  - CPU push accepted when count<DEPTH, or when a stream pop (tx_valid && tx_ready) happens in the same cycle. In that case count is unchanged and the pushed data lands behind the remaining entries.
  - Push to a full FIFO with no simultaneous pop: data dropped, tx_ovf set, pointers unchanged.
- RX FIFO: mirror behaviour.
  - rx_ready = !rx_full, from the registered count.
  - Producer push on rx_valid && rx_ready.
  - CPU pop of an empty RX FIFO returns 0 and sets rx_unf.
  - Simultaneous producer push and CPU pop with count>0: count unchanged, data order preserved.
  - Push into an empty FIFO is visible on RXDATA the next cycle; there is no fall-through.
- Sticky flags tx_ovf/rx_unf:
  - Clear on CTRL bit2.
  - A set event in the same cycle as a clear wins, so the flag stays 1.
- Flush (CTRL bit0): both FIFOs emptied and pointers zeroed. Flush overrides any push or pop in the same cycle, on either side. ie and the sticky flags are unaffected.
- Reset: pointers and counts 0, ie=0, flags 0.
  - Outputs after reset: tx_valid=0, rx_ready=1, irq=0, tx_data=0.
  - FIFO storage is not reset. tx_data is forced to 0 whenever the TX FIFO is empty.
  - Reset in mid-transfer discards all contents.
- Accesses outside the window: sel=0, no state change, ddata_r=0.

Optional Feature:
- Macro DMEM_STREAM_IRQ_EN.
- Defined: irq is registered and equals ie && (!rx_empty || tx_empty), updated every cycle, reset 0.
- Undefined: irq tied 0, ie still writable and readable, no interrupt logic synthesised.

Test Plan:
- Reset, then read STATUS (daddr=0x3F8) -> ddata_r=0x0000_000A (tx_empty, rx_empty); tx_valid=0, rx_ready=1.
- CPU writes 0x11,0x22,0x33 to 0x3F0 with tx_ready=0 -> tx_valid=1, tx_data=0x11, tx_count=3. Raise tx_ready -> 0x11,0x22,0x33 on consecutive cycles, then tx_valid=0.
- DEPTH=8: 9 writes to TXDATA with tx_ready=0 -> STATUS tx_full=1, tx_ovf=1, count 8; drain yields the first 8 words only. A write coinciding with a pop while full -> accepted.
- Producer pushes 0xA5A5_0001..0xA5A5_0008 -> rx_ready falls after the 8th. CPU reads 0x3F4 eight times -> words in order. A ninth read -> 0, rx_unf=1. CTRL write 0x4 -> rx_unf=0.
- FIFOs half full; CTRL write 0x1 in the same cycle as tx pop and rx push -> both counts 0 next cycle, sticky flags unchanged.
- With DMEM_STREAM_IRQ_EN: CTRL=0x2, idle -> irq=1 (tx_empty). Fill TX with one word and keep RX empty -> irq=0. RX push -> irq=1 one cycle later. Assert RST mid-sequence -> irq=0, counts 0.

Source files
------------

// File: rtl/dmem_stream_port.sv
// Memory-mapped TX/RX stream FIFOs on the core's data bus (16-byte window at BASE_ADDR).
// Optional registered interrupt is built when DMEM_STREAM_IRQ_EN is defined; otherwise irq is tied low.
module dmem_stream_port #(
    parameter logic [9:0] BASE_ADDR = 10'h3F0,
    parameter int         DEPTH     = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [9:0]  daddr,
    input  logic [31:0] ddata_w,
    input  logic        d_w,
    input  logic        d_r,
    output logic [31:0] ddata_r,
    output logic        sel,
    output logic [31:0] tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [31:0] rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        irq
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Stream handshakes: a word moves on a rising edge where valid && ready;
    // valid never waits for ready, and ready reflects only registered FIFO state.
    logic [31:0]   tx_mem [DEPTH];
    logic [31:0]   rx_mem [DEPTH];
    logic [AW-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
    logic [CW-1:0] tx_count, rx_count;
    logic          tx_ovf, rx_unf, ie;

    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic [1:0]    off;
    logic          bus_wr, bus_rd, flush, clr_flags, ctrl_wr;
    logic          tx_push_req, tx_pop, tx_push, tx_ovf_evt;
    logic          rx_pop_req, rx_pop, rx_push, rx_unf_evt;
    logic [31:0]   status;
    logic          unused_addr_bits;

    assign sel      = (daddr[9:4] == BASE_ADDR[9:4]);
    assign off      = daddr[3:2];
    assign bus_wr   = sel && d_w;
    assign bus_rd   = sel && d_r;
    assign unused_addr_bits = ^daddr[1:0];

    assign tx_full  = (tx_count == CW'(DEPTH));
    assign tx_empty = (tx_count == '0);
    assign rx_full  = (rx_count == CW'(DEPTH));
    assign rx_empty = (rx_count == '0);

    assign ctrl_wr   = bus_wr && (off == 2'd3);
    assign flush     = ctrl_wr && ddata_w[0];
    assign clr_flags = ctrl_wr && ddata_w[2];

    // A push into a full TX FIFO still fits when the head leaves on the same edge.
    assign tx_valid    = !tx_empty;
    assign tx_pop      = tx_valid && tx_ready;
    assign tx_push_req = bus_wr && (off == 2'd0);
    assign tx_push     = tx_push_req && (!tx_full || tx_pop);
    assign tx_ovf_evt  = tx_push_req && tx_full && !tx_pop;
    assign tx_data     = tx_empty ? 32'h0 : tx_mem[tx_rd];

    assign rx_ready    = !rx_full;
    assign rx_push     = rx_valid && rx_ready;
    assign rx_pop_req  = bus_rd && (off == 2'd1);
    assign rx_pop      = rx_pop_req && !rx_empty;
    assign rx_unf_evt  = rx_pop_req && rx_empty;

    assign status = {8'h00, 8'(rx_count), 8'(tx_count), 2'b00,
                     rx_unf, tx_ovf, rx_empty, rx_full, tx_empty, tx_full};

    always_comb begin
        ddata_r = 32'h0;
        if (bus_rd) begin
            case (off)
                2'd1:    ddata_r = rx_empty ? 32'h0 : rx_mem[rx_rd];
                2'd2:    ddata_r = status;
                2'd3:    ddata_r = {30'b0, ie, 1'b0};
                default: ddata_r = 32'h0;
            endcase
        end
    end

    // Storage is deliberately not reset; emptiness is tracked by the counts.
    always_ff @(posedge CLK) begin
        if (!RST && !flush && tx_push) tx_mem[tx_wr] <= ddata_w;
        if (!RST && !flush && rx_push) rx_mem[rx_wr] <= rx_data;
    end

    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            tx_wr    <= '0;
            tx_rd    <= '0;
            tx_count <= '0;
            rx_wr    <= '0;
            rx_rd    <= '0;
            rx_count <= '0;
        end else begin
            if (tx_push) tx_wr <= tx_wr + AW'(1);
            if (tx_pop)  tx_rd <= tx_rd + AW'(1);
            if (tx_push && !tx_pop)      tx_count <= tx_count + CW'(1);
            else if (tx_pop && !tx_push) tx_count <= tx_count - CW'(1);

            if (rx_push) rx_wr <= rx_wr + AW'(1);
            if (rx_pop)  rx_rd <= rx_rd + AW'(1);
            if (rx_push && !rx_pop)      rx_count <= rx_count + CW'(1);
            else if (rx_pop && !rx_push) rx_count <= rx_count - CW'(1);
        end
    end

    // Sticky flags: a set event on the same edge as a clear keeps the flag high.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tx_ovf <= 1'b0;
            rx_unf <= 1'b0;
            ie     <= 1'b0;
        end else begin
            if (tx_ovf_evt)     tx_ovf <= 1'b1;
            else if (clr_flags) tx_ovf <= 1'b0;
            if (rx_unf_evt)     rx_unf <= 1'b1;
            else if (clr_flags) rx_unf <= 1'b0;
            if (ctrl_wr)        ie     <= ddata_w[1];
        end
    end

`ifdef DMEM_STREAM_IRQ_EN
    always_ff @(posedge CLK) begin
        if (RST) irq <= 1'b0;
        else     irq <= ie && (!rx_empty || tx_empty);
    end
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_stream_port.sv
// Scoreboard bench for dmem_stream_port: directed test-plan sequences plus a randomised bus/stream mix.
// irq expectations follow DMEM_STREAM_IRQ_EN when the bench is built with it.
module tb_dmem_stream_port;
    localparam int DEPTH = 8;

    localparam int OP_IDLE  = 0;
    localparam int OP_TXW   = 1;
    localparam int OP_RXR   = 2;
    localparam int OP_STAT  = 3;
    localparam int OP_CTRL  = 4;
    localparam int OP_CTRLR = 5;
    localparam int OP_TXR   = 6;
    localparam int OP_OOBW  = 7;
    localparam int OP_OOBR  = 8;

    logic        CLK = 1'b0;
    logic        RST;
    logic [9:0]  daddr;
    logic [31:0] ddata_w;
    logic        d_w, d_r;
    logic [31:0] ddata_r;
    logic        sel;
    logic [31:0] tx_data;
    logic        tx_valid, tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid, rx_ready;
    logic        irq;

    dmem_stream_port #(.BASE_ADDR(10'h3F0), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .daddr(daddr), .ddata_w(ddata_w), .d_w(d_w), .d_r(d_r),
        .ddata_r(ddata_r), .sel(sel), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .irq(irq)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // ---------------- scoreboard state ----------------
    logic [31:0] tx_exp_q[$];
    logic [31:0] rx_exp_q[$];
    logic        tx_ovf_m, rx_unf_m, ie_m, irq_m;
    logic [31:0] last_rdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        int tc = tx_exp_q.size();
        int rc = rx_exp_q.size();
        return {8'h00, 8'(rc), 8'(tc), 2'b00, rx_unf_m, tx_ovf_m,
                (rc == 0), (rc == DEPTH), (tc == 0), (tc == DEPTH)};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        d_w = 1'b0; d_r = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0;
        daddr = 10'h000; ddata_w = '0; rx_data = '0;
        tick();
        tick();
        RST = 1'b0;
        tx_exp_q.delete();
        rx_exp_q.delete();
        tx_ovf_m = 1'b0; rx_unf_m = 1'b0; ie_m = 1'b0; irq_m = 1'b0;
    endtask

    // ---------------- driver: one bus op plus stream activity per cycle ----------------
    task automatic cycle_op(input int op, input logic [31:0] wd, input logic trdy,
                            input logic rv, input logic [31:0] rd);
        logic [9:0]  base;
        logic        in_win, tx_pop, full_before, rx_push, rx_had, flush, clr, irq_next;
        logic [31:0] exp_rd;
        case (op)
            OP_TXW, OP_TXR:   base = 10'h3F0;
            OP_RXR:           base = 10'h3F4;
            OP_STAT:          base = 10'h3F8;
            OP_CTRL, OP_CTRLR: base = 10'h3FC;
            OP_OOBW, OP_OOBR: base = 10'h3E0;
            default:          base = 10'h000;
        endcase
        in_win  = !(op == OP_IDLE || op == OP_OOBW || op == OP_OOBR);
        daddr   = base | 10'($urandom_range(0, 3));
        ddata_w = wd;
        d_w     = (op == OP_TXW || op == OP_CTRL || op == OP_OOBW);
        d_r     = (op == OP_RXR || op == OP_STAT || op == OP_CTRLR || op == OP_TXR || op == OP_OOBR);
        tx_ready = trdy;
        rx_valid = rv;
        rx_data  = rd;
        #1;
        check("tx_valid", 32'(tx_valid), 32'(tx_exp_q.size() != 0));
        check("tx_data", tx_data, (tx_exp_q.size() != 0) ? tx_exp_q[0] : 32'h0);
        check("rx_ready", 32'(rx_ready), 32'(rx_exp_q.size() < DEPTH));
        check("sel", 32'(sel), 32'(in_win));
        check("irq", 32'(irq), 32'(irq_m));
        if (d_r) begin
            case (op)
                OP_RXR:   exp_rd = (rx_exp_q.size() != 0) ? rx_exp_q[0] : 32'h0;
                OP_STAT:  exp_rd = exp_status();
                OP_CTRLR: exp_rd = {30'b0, ie_m, 1'b0};
                default:  exp_rd = 32'h0;
            endcase
            check("ddata_r", ddata_r, exp_rd);
            last_rdata = ddata_r;
        end else begin
            check("ddata_r_idle", ddata_r, 32'h0);
        end

        // expected state after this edge
        irq_next    = ie_m && ((rx_exp_q.size() != 0) || (tx_exp_q.size() == 0));
        flush       = (op == OP_CTRL) && wd[0];
        clr         = (op == OP_CTRL) && wd[2];
        tx_pop      = trdy && (tx_exp_q.size() != 0);
        full_before = (tx_exp_q.size() == DEPTH);
        rx_push     = rv && (rx_exp_q.size() < DEPTH);
        rx_had      = (rx_exp_q.size() != 0);
        if (flush) begin
            tx_exp_q.delete();
            rx_exp_q.delete();
        end else begin
            if (tx_pop) void'(tx_exp_q.pop_front());
            if (op == OP_TXW && (!full_before || tx_pop)) tx_exp_q.push_back(wd);
            if (op == OP_RXR && rx_had) void'(rx_exp_q.pop_front());
            if (rx_push) rx_exp_q.push_back(rd);
        end
        if (op == OP_TXW && full_before && !tx_pop) tx_ovf_m = 1'b1;
        else if (clr) tx_ovf_m = 1'b0;
        if (op == OP_RXR && !rx_had) rx_unf_m = 1'b1;
        else if (clr) rx_unf_m = 1'b0;
        if (op == OP_CTRL) ie_m = wd[1];
`ifdef DMEM_STREAM_IRQ_EN
        irq_m = irq_next;
`else
        irq_m = 1'b0;
`endif
        tick();
        d_w = 1'b0; d_r = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0; daddr = 10'h000;
    endtask

    task automatic drain_tx();
        int budget = 2 * DEPTH + 4;
        while (tx_exp_q.size() != 0 && budget > 0) begin
            cycle_op(OP_IDLE, 32'h0, 1'b1, 1'b0, 32'h0);
            budget--;
        end
        check("drain_done", 32'(tx_exp_q.size()), 32'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int op;
        last_rdata = '0;
        do_reset();

        // reset state
        cycle_op(OP_STAT, 32'h0, 1'b0, 1'b0, 32'h0);
        check("reset_status", last_rdata, 32'h0000_000A);

        // three words, then stream them out
        cycle_op(OP_TXW, 32'h11, 1'b0, 1'b0, 32'h0);
        cycle_op(OP_TXW, 32'h22, 1'b0, 1'b0, 32'h0);
        cycle_op(OP_TXW, 32'h33, 1'b0, 1'b0, 32'h0);
        cycle_op(OP_STAT, 32'h0, 1'b0, 1'b0, 32'h0);
        check("status_3w", last_rdata, 32'h0000_0308);
        drain_tx();

        // overflow, then a push coinciding with a pop while full
        for (int i = 0; i < 9; i++) cycle_op(OP_TXW, 32'h100 + 32'(i), 1'b0, 1'b0, 32'h0);
        cycle_op(OP_STAT, 32'h0, 1'b0, 1'b0, 32'h0);
        check("status_ovf", last_rdata, 32'h0000_0819);
        cycle_op(OP_TXW, 32'h999, 1'b1, 1'b0, 32'h0);
        cycle_op(OP_STAT, 32'h0, 1'b0, 1'b0, 32'h0);
        check("status_full_pp", last_rdata, 32'h0000_0819);
        drain_tx();
        cycle_op(OP_CTRL, 32'h4, 1'b0, 1'b0, 32'h0);
        cycle_op(OP_STAT, 32'h0, 1'b0, 1'b0, 32'h0);
        check("status_clr_ovf", last_rdata, 32'h0000_000A);

        // producer fills RX, extra word dropped, CPU drains, underflow
        for (int i = 1; i <= 9; i++) cycle_op(OP_IDLE, 32'h0, 1'b0, 1'b1, 32'hA5A5_0000 + 32'(i));
        cycle_op(OP_STAT, 32'h0, 1'b0, 1'b0, 32'h0);
        check("status_rx_full", last_rdata, 32'h0008_0006);
        for (int i = 0; i < DEPTH; i++) cycle_op(OP_RXR, 32'h0, 1'b0, 1'b0, 32'h0);
        check("rx_last_word", last_rdata, 32'hA5A5_0008);
        cycle_op(OP_RXR, 32'h0, 1'b0, 1'b0, 32'h0);
        check("rx_unf_read", last_rdata, 32'h0);
        cycle_op(OP_STAT, 32'h0, 1'b0, 1'b0, 32'h0);
        check("status_unf", last_rdata, 32'h0000_002A);
        cycle_op(OP_CTRL, 32'h4, 1'b0, 1'b0, 32'h0);
        cycle_op(OP_STAT, 32'h0, 1'b0, 1'b0, 32'h0);
        check("status_clr_unf", last_rdata, 32'h0000_000A);

        // TXDATA reads as 0; accesses outside the window do nothing
        cycle_op(OP_TXW, 32'h77, 1'b0, 1'b0, 32'h0);
        cycle_op(OP_TXR, 32'h0, 1'b0, 1'b0, 32'h0);
        check("txdata_read", last_rdata, 32'h0);
        cycle_op(OP_OOBW, 32'h55, 1'b0, 1'b0, 32'h0);
        cycle_op(OP_OOBR, 32'h0, 1'b0, 1'b0, 32'h0);
        check("oob_read", last_rdata, 32'h0);
        drain_tx();

        // flush with simultaneous tx pop and rx push; rx_unf and ie survive
        cycle_op(OP_RXR, 32'h0, 1'b0, 1'b0, 32'h0);
        cycle_op(OP_CTRL, 32'h2, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 4; i++) cycle_op(OP_TXW, 32'hC0 + 32'(i), 1'b0, 1'b1, 32'hD0 + 32'(i));
        cycle_op(OP_CTRL, 32'h3, 1'b1, 1'b1, 32'hEE);
        cycle_op(OP_STAT, 32'h0, 1'b0, 1'b0, 32'h0);
        check("status_flush", last_rdata, 32'h0000_002A);
        cycle_op(OP_CTRLR, 32'h0, 1'b0, 1'b0, 32'h0);
        check("ctrl_ie_kept", last_rdata, 32'h0000_0002);
        cycle_op(OP_CTRL, 32'h4, 1'b0, 1'b0, 32'h0);

        // interrupt sequence
        cycle_op(OP_CTRL, 32'h2, 1'b0, 1'b0, 32'h0);
        cycle_op(OP_IDLE, 32'h0, 1'b0, 1'b0, 32'h0);
        cycle_op(OP_TXW, 32'hABCD, 1'b0, 1'b0, 32'h0);
        cycle_op(OP_IDLE, 32'h0, 1'b0, 1'b0, 32'h0);
        cycle_op(OP_IDLE, 32'h0, 1'b0, 1'b1, 32'h1234);
        cycle_op(OP_IDLE, 32'h0, 1'b0, 1'b0, 32'h0);
`ifdef DMEM_STREAM_IRQ_EN
        check("irq_rx_pending", 32'(irq), 32'h1);
`else
        check("irq_tied_low", 32'(irq), 32'h0);
`endif
        do_reset();
        check("irq_after_rst", 32'(irq), 32'h0);
        cycle_op(OP_STAT, 32'h0, 1'b0, 1'b0, 32'h0);
        check("status_after_rst", last_rdata, 32'h0000_000A);

        // randomised mix against the scoreboard
        for (int i = 0; i < 400; i++) begin
            op = $urandom_range(0, 99);
            if (op < 30)      op = OP_TXW;
            else if (op < 55) op = OP_RXR;
            else if (op < 65) op = OP_STAT;
            else if (op < 68) op = OP_CTRL;
            else if (op < 71) op = OP_CTRLR;
            else if (op < 74) op = OP_OOBW;
            else              op = OP_IDLE;
            cycle_op(op, (op == OP_CTRL) ? 32'($urandom_range(0, 7)) & 32'h6 | 32'($urandom_range(0, 19) == 0)
                                         : 32'($urandom()),
                     1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), 32'($urandom()));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
